// File: rtl/rvv_commit_trace_if.sv
// Commit-record stream carried from the trace stage to its consumer.
// Handshake: a record transfers on a clk edge where out_valid && out_ready; the source holds all out_* stable while out_valid && !out_ready.
interface rvv_commit_trace_if #(
  parameter int XLEN            = 32,
  parameter int VLEN            = 128,
  parameter int DATA_ADDR_WIDTH = 10,
  parameter int TS_WIDTH        = 32
);
  logic                       out_valid;
  logic                       out_ready;
  logic [TS_WIDTH-1:0]        out_ts;
  logic [2:0]                 out_mask;
  logic [9:0]                 out_pc;
  logic [4:0]                 out_xaddr;
  logic [XLEN-1:0]            out_xdata;
  logic [4:0]                 out_vaddr;
  logic [VLEN-1:0]            out_vdata;
  logic [DATA_ADDR_WIDTH-1:0] out_maddr;
  logic [7:0]                 out_mdata;

  modport master (
    output out_valid, out_ts, out_mask, out_pc, out_xaddr, out_xdata,
           out_vaddr, out_vdata, out_maddr, out_mdata,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_ts, out_mask, out_pc, out_xaddr, out_xdata,
           out_vaddr, out_vdata, out_maddr, out_mdata,
    output out_ready
  );
endinterface

// File: rtl/rvv_commit_trace.sv
// Packs every architectural write (scalar RF, vector RF, DMEM byte) of a cycle into one
// cycle-stamped record and queues it in a first-word fall-through FIFO for the logger.
module rvv_commit_trace #(
  parameter int XLEN            = 32,
  parameter int VLEN            = 128,
  parameter int DATA_ADDR_WIDTH = 10,
  parameter int DEPTH           = 8,
  parameter int TS_WIDTH        = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       trace_en,
  input  logic                       x_we,
  input  logic [4:0]                 x_waddr,
  input  logic [XLEN-1:0]            x_wdata,
  input  logic                       v_we,
  input  logic [4:0]                 v_waddr,
  input  logic [VLEN-1:0]            v_wdata,
  input  logic                       m_we,
  input  logic [DATA_ADDR_WIDTH-1:0] m_waddr,
  input  logic [7:0]                 m_wdata,
  input  logic [9:0]                 pc,
  rvv_commit_trace_if.master         trace,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [15:0]                drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  typedef struct packed {
    logic [TS_WIDTH-1:0]        ts;
    logic [2:0]                 mask;
    logic [9:0]                 pc;
    logic [4:0]                 xaddr;
    logic [XLEN-1:0]            xdata;
    logic [4:0]                 vaddr;
    logic [VLEN-1:0]            vdata;
    logic [DATA_ADDR_WIDTH-1:0] maddr;
    logic [7:0]                 mdata;
  } rec_t;

  rec_t                mem [DEPTH];
  rec_t                new_rec;
  rec_t                head;
  logic [TS_WIDTH-1:0] ts;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic                x_ev;
  logic                v_ev;
  logic                m_ev;
  logic                push_req;
  logic                pop;
  logic                full;
  logic                push_ok;
  logic                drop;

  // x0 is hardwired zero, so writes to it are not architectural state changes
  assign x_ev     = x_we && (x_waddr != 5'd0);
  assign v_ev     = v_we;
  assign m_ev     = m_we;
  assign push_req = trace_en && (x_ev || v_ev || m_ev);
  assign full     = (count == FULL_COUNT);
  assign pop      = trace.out_valid && trace.out_ready;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    new_rec      = '0;
    new_rec.ts   = ts;
    new_rec.mask = {m_ev, v_ev, x_ev};
    new_rec.pc   = pc;
    if (x_ev) begin
      new_rec.xaddr = x_waddr;
      new_rec.xdata = x_wdata;
    end
    if (v_ev) begin
      new_rec.vaddr = v_waddr;
      new_rec.vdata = v_wdata;
    end
    if (m_ev) begin
      new_rec.maddr = m_waddr;
      new_rec.mdata = m_wdata;
    end
  end

  // Storage needs no reset: an empty FIFO masks the head to zero below.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= new_rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts       <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    head = '0;
    if (count != '0) head = mem[rd_ptr];
  end

  assign trace.out_valid = (count != '0);
  assign trace.out_ts    = head.ts;
  assign trace.out_mask  = head.mask;
  assign trace.out_pc    = head.pc;
  assign trace.out_xaddr = head.xaddr;
  assign trace.out_xdata = head.xdata;
  assign trace.out_vaddr = head.vaddr;
  assign trace.out_vdata = head.vdata;
  assign trace.out_maddr = head.maddr;
  assign trace.out_mdata = head.mdata;
endmodule

// File: tb/tb_rvv_commit_trace.sv
// Directed and random stimulus for rvv_commit_trace, checked against a queue of expected records.
module tb_rvv_commit_trace;
  localparam int XLEN  = 32;
  localparam int VLEN  = 128;
  localparam int AW    = 10;
  localparam int DEPTH = 8;
  localparam int TSW   = 32;
  localparam int REC_W = TSW + 3 + 10 + 5 + XLEN + 5 + VLEN + AW + 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            trace_en;
  logic            x_we;
  logic [4:0]      x_waddr;
  logic [XLEN-1:0] x_wdata;
  logic            v_we;
  logic [4:0]      v_waddr;
  logic [VLEN-1:0] v_wdata;
  logic            m_we;
  logic [AW-1:0]   m_waddr;
  logic [7:0]      m_wdata;
  logic [9:0]      pc;
  logic [3:0]      count;
  logic            overflow;
  logic [15:0]     drop_cnt;

  rvv_commit_trace_if #(.XLEN(XLEN), .VLEN(VLEN), .DATA_ADDR_WIDTH(AW), .TS_WIDTH(TSW)) tr ();

  rvv_commit_trace #(
    .XLEN(XLEN), .VLEN(VLEN), .DATA_ADDR_WIDTH(AW), .DEPTH(DEPTH), .TS_WIDTH(TSW)
  ) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en),
    .x_we(x_we), .x_waddr(x_waddr), .x_wdata(x_wdata),
    .v_we(v_we), .v_waddr(v_waddr), .v_wdata(v_wdata),
    .m_we(m_we), .m_waddr(m_waddr), .m_wdata(m_wdata),
    .pc(pc), .trace(tr), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  // clock / reset-tracked cycle stamp
  always #5 clk = ~clk;

  logic [TSW-1:0] tb_ts;
  always @(posedge clk) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 1;
  end

  // scoreboard
  logic [REC_W-1:0] exp_q[$];
  logic             exp_ovf;
  logic [15:0]      exp_drops;
  int               checks;
  int               errors;

  function automatic logic [REC_W-1:0] dut_rec();
    return {tr.out_ts, tr.out_mask, tr.out_pc, tr.out_xaddr, tr.out_xdata,
            tr.out_vaddr, tr.out_vdata, tr.out_maddr, tr.out_mdata};
  endfunction

  task automatic chk(input string tag, input logic [REC_W-1:0] obs, input logic [REC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle_in();
    trace_en = 1'b1;
    x_we = 1'b0; x_waddr = '0; x_wdata = '0;
    v_we = 1'b0; v_waddr = '0; v_wdata = '0;
    m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    pc   = '0;
  endtask

  task automatic rand_in();
    trace_en = ($urandom_range(0, 3) != 0);
    x_we     = $urandom_range(0, 1);
    x_waddr  = $urandom_range(0, 31);
    x_wdata  = $urandom;
    v_we     = $urandom_range(0, 1);
    v_waddr  = $urandom_range(0, 31);
    v_wdata  = {$urandom, $urandom, $urandom, $urandom};
    m_we     = $urandom_range(0, 1);
    m_waddr  = $urandom_range(0, 1023);
    m_wdata  = $urandom_range(0, 255);
    pc       = $urandom_range(0, 1023);
  endtask

  // Checks the outputs of the current cycle, then advances the model and the clock.
  task automatic cycle();
    logic             xe, ve, me, push, pop;
    logic [4:0]       xa, va;
    logic [XLEN-1:0]  xd;
    logic [VLEN-1:0]  vd;
    logic [AW-1:0]    ma;
    logic [7:0]       md;
    logic [REC_W-1:0] nr;
    logic [REC_W-1:0] gone;
    chk("count", count, exp_q.size());
    chk("valid", tr.out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("head", dut_rec(), exp_q[0]);
    else                   chk("empty_zero", dut_rec(), '0);
    chk("overflow", overflow, exp_ovf);
    chk("drop_cnt", drop_cnt, exp_drops);
    xe = x_we && (x_waddr != 0);
    ve = v_we;
    me = m_we;
    xa = xe ? x_waddr : 5'd0;
    xd = xe ? x_wdata : {XLEN{1'b0}};
    va = ve ? v_waddr : 5'd0;
    vd = ve ? v_wdata : {VLEN{1'b0}};
    ma = me ? m_waddr : {AW{1'b0}};
    md = me ? m_wdata : 8'd0;
    nr = {tb_ts, me, ve, xe, pc, xa, xd, va, vd, ma, md};
    push = trace_en && (xe || ve || me);
    pop  = tr.out_ready && (exp_q.size() != 0);
    if (pop) gone = exp_q.pop_front();
    if (push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(nr);
      else begin
        exp_ovf = 1'b1;
        if (exp_drops != 16'hFFFF) exp_drops++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_ovf   = 1'b0;
    exp_drops = '0;
  endtask

  task automatic drain();
    idle_in();
    tr.out_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && exp_q.size() != 0; i++) cycle();
    cycle();
  endtask

  initial begin
    int pushes;
    checks = 0;
    errors = 0;
    tr.out_ready = 1'b0;
    do_reset();

    // Reset mid-stream
    for (int i = 0; i < 3; i++) begin
      idle_in();
      x_we = 1'b1; x_waddr = 5'(i + 1); x_wdata = $urandom; pc = 10'(i);
      cycle();
    end
    idle_in();
    cycle();
    do_reset();
    chk("rst_valid", tr.out_valid, 1'b0);
    chk("rst_count", count, 4'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_data", dut_rec(), '0);
    cycle();
    x_we = 1'b1; x_waddr = 5'd7; x_wdata = 32'h0000_1111;
    cycle();
    idle_in();
    chk("post_reset_ts", tr.out_ts, 1);
    cycle();
    drain();

    // x0 filter merged with a vector write
    x_we = 1'b1; x_waddr = 5'd0; x_wdata = 32'h1234_5678;
    v_we = 1'b1; v_waddr = 5'd3; v_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
    pc = 10'h040;
    cycle();
    idle_in();
    chk("x0_mask", tr.out_mask, 3'b010);
    chk("x0_xaddr", tr.out_xaddr, 5'd0);
    chk("x0_xdata", tr.out_xdata, 32'd0);
    chk("x0_vaddr", tr.out_vaddr, 5'd3);
    chk("x0_vdata", tr.out_vdata, 128'h0123456789ABCDEF0123456789ABCDEF);
    cycle();
    drain();

    // Scalar and memory write in the same cycle
    x_we = 1'b1; x_waddr = 5'd5; x_wdata = 32'hDEADBEEF;
    m_we = 1'b1; m_waddr = 10'h3FF; m_wdata = 8'hA5;
    pc = 10'h104;
    cycle();
    idle_in();
    chk("xm_mask", tr.out_mask, 3'b101);
    chk("xm_xaddr", tr.out_xaddr, 5'd5);
    chk("xm_xdata", tr.out_xdata, 32'hDEADBEEF);
    chk("xm_maddr", tr.out_maddr, 10'h3FF);
    chk("xm_mdata", tr.out_mdata, 8'hA5);
    chk("xm_vdata", tr.out_vdata, 128'd0);
    chk("xm_pc", tr.out_pc, 10'h104);
    cycle();
    drain();

    // Overflow with the consumer stalled
    do_reset();
    tr.out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      idle_in();
      x_we = 1'b1; x_waddr = 5'(i + 1); x_wdata = $urandom; pc = 10'(i + 16);
      cycle();
    end
    idle_in();
    chk("ovf_count", count, 4'd8);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_drops", drop_cnt, 16'd3);
    cycle();

    // Full: push and pop in the same cycle
    tr.out_ready = 1'b1;
    v_we = 1'b1; v_waddr = 5'd9; v_wdata = {4{32'hCAFE_F00D}};
    cycle();
    idle_in();
    tr.out_ready = 1'b0;
    chk("full_pp_count", count, 4'd8);
    chk("full_pp_drops", drop_cnt, 16'd3);
    cycle();
    drain();

    // Random backpressure, enable toggling, pointer wrap
    pushes = 0;
    for (int c = 0; c < 600 && pushes < 50; c++) begin
      rand_in();
      tr.out_ready = $urandom_range(0, 1);
      if (trace_en && ((x_we && x_waddr != 0) || v_we || m_we)) pushes++;
      cycle();
    end
    drain();
    chk("final_overflow_sticky", overflow, exp_ovf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
